// File: rtl/int_controller_pkg.sv
// Shared constants, state encodings and the priority helper for the
// hardware interrupt controller.
package int_controller_pkg;

  localparam logic [3:0] INT_ID_ERET         = 4'b1111;
  localparam int         DEFAULT_ACK_TIMEOUT = 8;
  localparam int         MAX_SRC             = 15;

  typedef enum logic [1:0] {
    INTC_IDLE    = 2'd0,
    INTC_REQ     = 2'd1,
    INTC_SERVICE = 2'd2
  } intc_state_e;

  // Lowest set index wins; an empty vector yields the reserved ERET ID.
  function automatic logic [3:0] prio_lowest(input logic [MAX_SRC-1:0] v);
    prio_lowest = INT_ID_ERET;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) prio_lowest = 4'(i);
    end
  endfunction

endpackage

// File: rtl/int_controller_if.sv
// Signal bundle between the interrupt controller (master) and the
// peripherals/pipeline/scheduler environment (slave).
interface int_controller_if #(parameter int NUM_SRC = 4);
  import int_controller_pkg::*;

  logic [NUM_SRC-1:0] inti_src;
  logic               inti_mask_we;
  logic [NUM_SRC-1:0] inti_mask_wdata;
  logic [15:0]        inti_pc;
  logic               inti_pc_valid;
  logic               inti_ack;
  logic               inti_eret;

  // Request handshake: into_hard_int rises with into_int_id/into_epc valid and
  // stays high until inti_ack (or the ack timeout); the falling edge is the
  // event the scheduler samples, and id/epc stay stable until after ERET.
  logic               into_hard_int;
  logic [3:0]         into_int_id;
  logic [15:0]        into_epc;
  logic [NUM_SRC-1:0] into_pending;
  logic [NUM_SRC-1:0] into_mask;
  logic               into_busy;
  intc_state_e        into_state;

  modport master (
    input  inti_src, inti_mask_we, inti_mask_wdata, inti_pc, inti_pc_valid,
           inti_ack, inti_eret,
    output into_hard_int, into_int_id, into_epc, into_pending, into_mask,
           into_busy, into_state
  );

  modport slave (
    output inti_src, inti_mask_we, inti_mask_wdata, inti_pc, inti_pc_valid,
           inti_ack, inti_eret,
    input  into_hard_int, into_int_id, into_epc, into_pending, into_mask,
           into_busy, into_state
  );

endinterface

// File: rtl/int_sync_edge.sv
// Multi-flop synchroniser for one asynchronous interrupt line followed by a
// rising-edge detector on the synchronised value.
module int_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign edge_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_controller.sv
// Hardware interrupt controller: latches synchronised source edges as pending,
// masks, picks the lowest eligible index and runs a one-outstanding request FSM.
module int_controller
  import int_controller_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic             inti_clk,
  input  logic             inti_rst,
  int_controller_if.master bus
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [NUM_SRC-1:0] edge_w;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr;
  logic [MAX_SRC-1:0] elig_ext;
  logic [3:0]         winner;
  logic               grant;
  logic               timeout;

  intc_state_e        state_q;
  logic               hard_q;
  logic [3:0]         id_q;
  logic [15:0]        epc_q;
  logic [CW-1:0]      cnt_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    int_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (inti_clk),
      .rst_ni (inti_rst),
      .async_i(bus.inti_src[g]),
      .edge_o (edge_w[g])
    );
  end

  assign eligible = pending_q & mask_q;
  assign grant    = (state_q == INTC_IDLE) && (|eligible) && bus.inti_pc_valid;
  assign timeout  = (cnt_q == CW'(ACK_TIMEOUT - 1));

  always_comb begin
    elig_ext = '0;
    elig_ext[NUM_SRC-1:0] = eligible;
    winner = prio_lowest(elig_ext);
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant && (winner == 4'(i))) clr[i] = 1'b1;
    end
    // A fresh edge on the line being granted keeps its pending bit set.
    pending_d = (pending_q & ~clr) | edge_w;
    mask_d    = bus.inti_mask_we ? bus.inti_mask_wdata : mask_q;
  end

  always_ff @(posedge inti_clk or negedge inti_rst) begin
    if (!inti_rst) begin
      pending_q <= '0;
      mask_q    <= '1;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // id/epc only change on a grant, so they stay stable through SERVICE.
  always_ff @(posedge inti_clk or negedge inti_rst) begin
    if (!inti_rst) begin
      state_q <= INTC_IDLE;
      hard_q  <= 1'b0;
      id_q    <= '0;
      epc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        INTC_IDLE: begin
          if (grant) begin
            state_q <= INTC_REQ;
            hard_q  <= 1'b1;
            id_q    <= winner;
            epc_q   <= bus.inti_pc;
            cnt_q   <= '0;
          end
        end
        INTC_REQ: begin
          if (bus.inti_ack || timeout) begin
            state_q <= INTC_SERVICE;
            hard_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        INTC_SERVICE: begin
          if (bus.inti_eret) state_q <= INTC_IDLE;
        end
        default: begin
          state_q <= INTC_IDLE;
          hard_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.into_hard_int = hard_q;
  assign bus.into_int_id   = id_q;
  assign bus.into_epc      = epc_q;
  assign bus.into_pending  = pending_q;
  assign bus.into_mask     = mask_q;
  assign bus.into_busy     = (state_q != INTC_IDLE);
  assign bus.into_state    = state_q;

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Hardware-interrupt source for the CPU interrupt scheduler. The scheduler is the consumer of this block's outputs.
- Synchronises asynchronous peripheral interrupt lines (UART, timer, keyboard), latches rising edges as pending, and applies a software mask.
- Selects one source by fixed priority and drives a single hard-interrupt request with source ID and the faulting PC.
- Handshakes with the scheduler's acknowledge, then blocks further requests until ERET.

Parameters:
- NUM_SRC, 4, number of interrupt source lines (1..15; ID 4'b1111 is reserved for ERET).
- SYNC_STAGES, 2, synchroniser flops per source line.
- ACK_TIMEOUT, 8, cycles in REQ without ack before the request is forcibly dropped.

Ports:
- inti_clk  in  1  system clock
- inti_rst  in  1  asynchronous active-low reset
- inti_src  in  NUM_SRC  raw asynchronous interrupt lines, active high
- inti_mask_we  in  1  mask write strobe
- inti_mask_wdata  in  NUM_SRC  new mask value; 1 = enabled
- inti_pc  in  16  PC of the instruction to resume at
- inti_pc_valid  in  1  pipeline not stalled; inti_pc is meaningful
- inti_ack  in  1  scheduler interrupt_set_pc
- inti_eret  in  1  one-cycle pulse: ERET executed
- into_hard_int  out  1  hard-interrupt request; the falling edge is the event the scheduler samples
- into_int_id  out  4  granted source index
- into_epc  out  16  captured PC for the granted interrupt
- into_pending  out  NUM_SRC  pending vector
- into_mask  out  NUM_SRC  current mask
- into_busy  out  1  state != IDLE

Behaviour:
- Reset (async, inti_rst=0):
  - into_hard_int=0, into_int_id=0, into_epc=0, into_pending=0, into_mask=all ones, into_busy=0.
  - State goes to IDLE; synchronisers, edge registers and timeout counter are cleared.
  - Reset mid-request drops into_hard_int immediately.
- Source path:
  - Each line passes through SYNC_STAGES flops, then a rising-edge detector.
  - A detected edge sets pending[i] one cycle after the synchronised rise.
  - Level-high lines produce only one edge.
- Mask:
  - inti_mask_we loads inti_mask_wdata; it is visible to arbitration from the next cycle.
  - Masked pending bits are retained, not discarded.
- Eligible = pending & mask. Priority: lowest index wins.
- FSM: states IDLE, REQ, SERVICE.
  - IDLE: if eligible!=0 and inti_pc_valid, then on the next edge:
    - into_epc<=inti_pc, into_int_id<=winner index, pending[winner] cleared, state<=REQ, into_hard_int<=1, timeout counter<=0.
    - If eligible but inti_pc_valid=0, stay in IDLE.
  - REQ:
    - into_hard_int held at 1; into_epc and into_int_id held stable.
    - On inti_ack=1: state<=SERVICE, into_hard_int<=0.
    - If the counter reaches ACK_TIMEOUT-1 without ack: same transition (forced drop), so the falling edge still occurs.
    - inti_eret is ignored in REQ.
  - SERVICE:
    - into_hard_int=0; into_epc and into_int_id held unchanged for at least 2 cycles after the falling edge, so the scheduler's negedge capture sees stable data.
    - New edges keep accumulating in pending.
    - inti_eret=1: state<=IDLE.
    - The first new grant is possible the cycle after IDLE is entered, so there is at least one idle cycle between requests.
  - inti_eret in IDLE is ignored.
- Simultaneous events:
  - New edge on the source being granted, in the same cycle: pending[i] stays set (set wins over clear).
  - Mask write in the same cycle as a grant: the grant uses the old mask.
  - inti_ack and timeout in the same cycle: single transition to SERVICE.
- No nesting: at most one interrupt outstanding.
- into_pending and into_mask are registered outputs.

Decomposition:
- Constants added to the shared defines.v:
  - INT_ID_ERET (4'b1111), the reserved ERET ID.
  - Controller state encodings: INTC_IDLE, INTC_REQ, INTC_SERVICE.
  - Default ACK_TIMEOUT value.
- Sub-module int_sync_edge: per-line SYNC_STAGES synchroniser plus rising-edge detector, instantiated NUM_SRC times via generate.
- Priority encoding and the FSM stay in int_controller.

Test Plan:
- Single source: pulse inti_src[2] with inti_pc=16'h0123 and pc_valid=1.
  - into_pending[2]=1 after 3 cycles; into_hard_int rises next cycle with into_int_id=2 and into_epc=16'h0123.
  - inti_ack at +2 cycles: into_hard_int falls the following cycle, busy stays 1.
  - inti_eret: busy=0.
- Priority: raise src[3] and src[1] in the same cycle.
  - Grant ID 1 first; pending=4'b1000 remains.
  - After ack+eret, ID 3 is granted one idle cycle later.
- Mask: write mask=4'b1110, then pulse src[0].
  - pending[0]=1, no request.
  - Write mask=4'b1111: request with ID 0 on the next cycle.
- Timeout: grant with inti_ack held 0.
  - into_hard_int drops after exactly 8 cycles high; state is SERVICE; into_epc unchanged.
- Stall and simultaneity:
  - Eligible pending with pc_valid=0 for 5 cycles: no request. pc_valid=1 then grants with that cycle's inti_pc.
  - New src edge on the granted line in the grant cycle leaves pending set.
- Reset mid-REQ: deassert inti_rst while into_hard_int=1.
  - All outputs go to reset values asynchronously; mask=4'b1111; no request after release until a new edge.
